ibuf_load_ctrl: RTL and testbench

Sequencer for the row of input column buffers feeding the MAC array. On `Start` it fetches `NumTiles` tiles of `NCOL` 32-bit words from input SRAM and writes one word into each column buffer. It then issues `NCOL` shift pulses so that each buffer drains its four bytes into the array, and repeats until all tiles are consumed. It sits between the top-level control FSM and the `IBuffer_col` instances, one controller per buffer row.

---
 rtl/ibuf_ctrl_pkg.sv | 17 +
 rtl/ibuf_load_ctrl.sv | 118 +++++++++++
 tb/tb_ibuf_load_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibuf_ctrl_pkg.sv
// rtl/ibuf_ctrl_pkg.sv - shared types and defaults for the input-buffer load controller
package ibuf_ctrl_pkg;

  localparam int NCOL_DEF = 4;
  localparam int AW_DEF   = 8;
  localparam int TW_DEF   = 8;
  localparam int WORD_W   = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_LWAIT = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/ibuf_load_ctrl.sv
// rtl/ibuf_load_ctrl.sv - tile load/shift sequencer for one row of input column buffers
module ibuf_load_ctrl
  import ibuf_ctrl_pkg::*;
#(
  parameter int NCOL = NCOL_DEF,
  parameter int AW   = AW_DEF,
  parameter int TW   = TW_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic [AW-1:0]     BaseAddr,
  input  logic [TW-1:0]     NumTiles,
  input  logic              Stall,
  output logic              MemRdEN,
  output logic [AW-1:0]     MemAddr,
  input  logic [WORD_W-1:0] MemRdata,
  output logic [NCOL-1:0]   WriteEN,
  output logic [WORD_W-1:0] IWord,
  output logic              ShiftEN,
  output logic              Busy,
  output logic              Done
);

  localparam int CW = $clog2(NCOL + 1);

  state_t          state;
  logic [AW-1:0]   addr;
  logic [TW-1:0]   ntiles;
  logic [TW-1:0]   t;
  logic [CW-1:0]   c;
  logic [CW-1:0]   s;
  logic [NCOL-1:0] wen;

  logic            last_col;
  logic            shift_done;
  logic            more_tiles;
  logic [TW:0]     t_inc;
  logic [NCOL-1:0] col_onehot;

  assign last_col   = (c == CW'(NCOL - 1));
  assign shift_done = (s == CW'(NCOL));
  assign t_inc      = {1'b0, t} + {{TW{1'b0}}, 1'b1};
  assign more_tiles = (t_inc < {1'b0, ntiles});
  assign col_onehot = NCOL'(1) << c;

  // The tile's last shift bumps s to NCOL; the tile decision is made in the following cycle.
  assign ShiftEN = (state == ST_SHIFT) && !Stall && !shift_done;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      addr   <= '0;
      ntiles <= '0;
      t      <= '0;
      c      <= '0;
      s      <= '0;
      wen    <= '0;
    end else begin
      // The write strobe trails the read by one cycle so it lines up with MemRdata.
      wen <= (state == ST_LOAD) ? col_onehot : '0;

      case (state)
        ST_IDLE: begin
          if (Start) begin
            addr   <= BaseAddr;
            ntiles <= NumTiles;
            t      <= '0;
            c      <= '0;
            s      <= '0;
            state  <= (NumTiles == '0) ? ST_DONE : ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Tiles are contiguous, so a running address replaces base + t*NCOL + c.
          addr <= addr + AW'(1);
          if (last_col) begin
            c     <= '0;
            state <= ST_LWAIT;
          end else begin
            c <= c + CW'(1);
          end
        end
        ST_LWAIT: begin
          s     <= '0;
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (shift_done) begin
            if (more_tiles) begin
              t     <= t + TW'(1);
              c     <= '0;
              state <= ST_LOAD;
            end else begin
              state <= ST_DONE;
            end
          end else if (ShiftEN) begin
            s <= s + CW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign MemRdEN = (state == ST_LOAD);
  assign MemAddr = addr;
  assign WriteEN = wen;
  assign IWord   = MemRdata;
  assign Busy    = (state == ST_LOAD) || (state == ST_LWAIT) || (state == ST_SHIFT);
  assign Done    = (state == ST_DONE);

endmodule

// File: tb/tb_ibuf_load_ctrl.sv
// tb/tb_ibuf_load_ctrl.sv - directed bench for ibuf_load_ctrl with column-buffer scoreboard
module tb_ibuf_load_ctrl;
  import ibuf_ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Start;
  logic [7:0]  BaseAddr;
  logic [7:0]  NumTiles;
  logic        Stall;
  logic        MemRdEN;
  logic [7:0]  MemAddr;
  logic [31:0] MemRdata;
  logic [3:0]  WriteEN;
  logic [31:0] IWord;
  logic        ShiftEN;
  logic        Busy;
  logic        Done;

  int errors = 0;
  int checks = 0;

  ibuf_load_ctrl #(.NCOL(4), .AW(8), .TW(8)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .BaseAddr(BaseAddr), .NumTiles(NumTiles),
    .Stall(Stall), .MemRdEN(MemRdEN), .MemAddr(MemAddr), .MemRdata(MemRdata),
    .WriteEN(WriteEN), .IWord(IWord), .ShiftEN(ShiftEN), .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [0:255];
  always @(posedge CLK) if (MemRdEN) MemRdata <= mem[MemAddr];

  // Per-cycle record: index k is cycle T+k after the Start edge T.
  logic       r_rd   [0:63];
  logic [7:0] r_addr [0:63];
  logic [3:0] r_wen  [0:63];
  logic       r_sen  [0:63];
  logic       r_busy [0:63];
  logic       r_done [0:63];
  logic       r_stall[0:63];
  state_t     r_st   [0:63];
  logic       s_stall[0:63];
  logic       s_start[0:63];
  logic       s_rst  [0:63];
  int         ovl;

  logic [31:0] mb [4];
  logic [7:0]  outq [4][$];

  task automatic clear_sched();
    for (int k = 0; k < 64; k++) begin
      s_stall[k] = 1'b0;
      s_start[k] = 1'b0;
      s_rst[k]   = 1'b0;
    end
  endtask

  task automatic run(input logic [7:0] base, input logic [7:0] n, input int ncyc);
    ovl = 0;
    for (int j = 0; j < 4; j++) begin
      mb[j] = 32'h0;
      outq[j].delete();
    end
    @(negedge CLK);
    BaseAddr = base;
    NumTiles = n;
    Start    = 1'b1;
    @(posedge CLK);
    #1;
    Start    = 1'b0;
    BaseAddr = 8'h80;
    NumTiles = 8'd5;
    for (int k = 1; k <= ncyc; k++) begin
      Stall = s_stall[k];
      Start = s_start[k];
      RST   = s_rst[k];
      @(negedge CLK);
      r_rd[k]    = MemRdEN;
      r_addr[k]  = MemAddr;
      r_wen[k]   = WriteEN;
      r_sen[k]   = ShiftEN;
      r_busy[k]  = Busy;
      r_done[k]  = Done;
      r_stall[k] = Stall;
      r_st[k]    = dut.state;
      if ((WriteEN != 4'b0) && ShiftEN) ovl++;
      for (int j = 0; j < 4; j++) begin
        if (WriteEN[j]) mb[j] = IWord;
        if (ShiftEN) begin
          outq[j].push_back(mb[j][31:24]);
          mb[j] = {mb[j][23:0], 8'h00};
        end
      end
      @(posedge CLK);
      #1;
    end
    Stall = 1'b0;
    Start = 1'b0;
    RST   = 1'b0;
  endtask

  function automatic int cnt_rd(int n);
    int r = 0;
    for (int k = 1; k <= n; k++) if (r_rd[k] === 1'b1) r++;
    return r;
  endfunction

  function automatic int cnt_wen(int n);
    int r = 0;
    for (int k = 1; k <= n; k++) if (r_wen[k] !== 4'b0) r++;
    return r;
  endfunction

  function automatic int cnt_sen(int n);
    int r = 0;
    for (int k = 1; k <= n; k++) if (r_sen[k] === 1'b1) r++;
    return r;
  endfunction

  function automatic int cnt_busy(int n);
    int r = 0;
    for (int k = 1; k <= n; k++) if (r_busy[k] === 1'b1) r++;
    return r;
  endfunction

  function automatic int cnt_done(int n);
    int r = 0;
    for (int k = 1; k <= n; k++) if (r_done[k] === 1'b1) r++;
    return r;
  endfunction

  function automatic int first_done(int n);
    for (int k = 1; k <= n; k++) if (r_done[k] === 1'b1) return k;
    return -1;
  endfunction

  task automatic test_reset();
    RST = 1'b1; Start = 1'b0; Stall = 1'b0; BaseAddr = 8'h00; NumTiles = 8'h00;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (MemRdEN !== 1'b0) begin errors++; $display("FAIL reset_rden got %b exp 0", MemRdEN); end
    checks++;
    if (MemAddr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", MemAddr); end
    checks++;
    if (WriteEN !== 4'b0) begin errors++; $display("FAIL reset_wen got %b exp 0000", WriteEN); end
    checks++;
    if (ShiftEN !== 1'b0) begin errors++; $display("FAIL reset_shift got %b exp 0", ShiftEN); end
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL reset_busy_done got %b%b exp 00", Busy, Done);
    end
    checks++;
    if (dut.state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp 0", dut.state); end
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] ea;
    logic [3:0] ew;
    clear_sched();
    run(8'h10, 8'd1, 14);
    for (int k = 1; k <= 4; k++) begin
      ea = 8'h10 + 8'(k - 1);
      checks++;
      if (r_rd[k] !== 1'b1 || r_addr[k] !== ea) begin
        errors++; $display("FAIL basic_read k=%0d got rd=%b addr=%h exp rd=1 addr=%h", k, r_rd[k], r_addr[k], ea);
      end
    end
    checks++;
    if (r_rd[5] !== 1'b0) begin errors++; $display("FAIL basic_rd_end got %b exp 0", r_rd[5]); end
    for (int k = 0; k < 4; k++) begin
      ew = 4'b0001 << k;
      checks++;
      if (r_wen[2 + k] !== ew) begin
        errors++; $display("FAIL basic_wen k=%0d got %b exp %b", k, r_wen[2 + k], ew);
      end
    end
    for (int k = 6; k <= 9; k++) begin
      checks++;
      if (r_sen[k] !== 1'b1) begin errors++; $display("FAIL basic_shift k=%0d got %b exp 1", k, r_sen[k]); end
    end
    checks++;
    if (cnt_sen(14) != 4) begin errors++; $display("FAIL basic_shift_cnt got %0d exp 4", cnt_sen(14)); end
    checks++;
    if (first_done(14) != 11 || cnt_done(14) != 1) begin
      errors++; $display("FAIL basic_done got cycle %0d count %0d exp cycle 11 count 1", first_done(14), cnt_done(14));
    end
    checks++;
    if (r_busy[10] !== 1'b1 || r_busy[11] !== 1'b0) begin
      errors++; $display("FAIL basic_busy got %b%b exp 10", r_busy[10], r_busy[11]);
    end
  endtask

  task automatic test_multi();
    int i;
    logic [7:0] ea;
    clear_sched();
    run(8'h10, 8'd3, 34);
    i = 0;
    for (int k = 1; k <= 34; k++) begin
      if (r_rd[k] === 1'b1) begin
        ea = 8'h10 + 8'(i);
        checks++;
        if (r_addr[k] !== ea) begin
          errors++; $display("FAIL multi_addr i=%0d got %h exp %h", i, r_addr[k], ea);
        end
        i++;
      end
    end
    checks++;
    if (cnt_rd(34) != 12) begin errors++; $display("FAIL multi_reads got %0d exp 12", cnt_rd(34)); end
    checks++;
    if (cnt_wen(34) != 12) begin errors++; $display("FAIL multi_writes got %0d exp 12", cnt_wen(34)); end
    checks++;
    if (cnt_sen(34) != 12) begin errors++; $display("FAIL multi_shifts got %0d exp 12", cnt_sen(34)); end
    checks++;
    if (first_done(34) != 31) begin errors++; $display("FAIL multi_done got %0d exp 31", first_done(34)); end
    checks++;
    if (ovl != 0) begin errors++; $display("FAIL multi_overlap got %0d exp 0", ovl); end
  endtask

  task automatic test_stall();
    int bad;
    clear_sched();
    s_stall[7] = 1'b1; s_stall[8] = 1'b1; s_stall[9] = 1'b1;
    run(8'h20, 8'd1, 18);
    checks++;
    if (cnt_sen(18) != 4) begin errors++; $display("FAIL stall_shifts got %0d exp 4", cnt_sen(18)); end
    checks++;
    if (first_done(18) != 14) begin errors++; $display("FAIL stall_done got %0d exp 14", first_done(18)); end
    bad = 0;
    for (int k = 1; k <= 18; k++) if (r_stall[k] === 1'b1 && r_sen[k] !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stall_gate got %0d shifts while stalled exp 0", bad); end
  endtask

  task automatic test_edges();
    logic [7:0] wa [4];
    int bad;
    wa[0] = 8'hFE; wa[1] = 8'hFF; wa[2] = 8'h00; wa[3] = 8'h01;
    clear_sched();
    run(8'h30, 8'd0, 4);
    checks++;
    if (first_done(4) != 1) begin errors++; $display("FAIL zero_done got %0d exp 1", first_done(4)); end
    checks++;
    if (cnt_rd(4) != 0 || cnt_busy(4) != 0) begin
      errors++; $display("FAIL zero_activity got reads=%0d busy=%0d exp 0 0", cnt_rd(4), cnt_busy(4));
    end
    run(8'hFE, 8'd1, 14);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (r_rd[k] !== 1'b1 || r_addr[k] !== wa[k - 1]) begin
        errors++; $display("FAIL wrap_addr k=%0d got %h exp %h", k, r_addr[k], wa[k - 1]);
      end
    end
    s_start[3] = 1'b1; s_start[8] = 1'b1; s_start[10] = 1'b1;
    run(8'h10, 8'd1, 20);
    checks++;
    if (cnt_rd(20) != 4 || cnt_done(20) != 1 || first_done(20) != 11) begin
      errors++; $display("FAIL busy_start got reads=%0d dones=%0d done_at=%0d exp 4 1 11", cnt_rd(20), cnt_done(20), first_done(20));
    end
    bad = 0;
    for (int k = 12; k <= 20; k++) if (r_busy[k] !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL busy_start_idle got %0d busy cycles exp 0", bad); end
  endtask

  task automatic test_reset_mid();
    clear_sched();
    s_rst[17] = 1'b1;
    run(8'h10, 8'd3, 24);
    checks++;
    if (r_sen[17] !== 1'b1) begin errors++; $display("FAIL rst_pre_shift got %b exp 1", r_sen[17]); end
    checks++;
    if (r_rd[18] !== 1'b0 || r_addr[18] !== 8'h00 || r_wen[18] !== 4'b0 || r_sen[18] !== 1'b0
        || r_busy[18] !== 1'b0 || r_done[18] !== 1'b0) begin
      errors++; $display("FAIL rst_outputs got rd=%b addr=%h wen=%b sen=%b busy=%b done=%b exp all 0",
                         r_rd[18], r_addr[18], r_wen[18], r_sen[18], r_busy[18], r_done[18]);
    end
    checks++;
    if (r_st[18] !== ST_IDLE) begin errors++; $display("FAIL rst_state got %0d exp 0", r_st[18]); end
    checks++;
    if (cnt_done(24) != 0) begin errors++; $display("FAIL rst_no_done got %0d exp 0", cnt_done(24)); end
    clear_sched();
    run(8'h10, 8'd1, 14);
    checks++;
    if (first_done(14) != 11 || cnt_sen(14) != 4) begin
      errors++; $display("FAIL rst_restart got done_at=%0d shifts=%0d exp 11 4", first_done(14), cnt_sen(14));
    end
  endtask

  task automatic test_scoreboard();
    logic [31:0] w;
    logic [7:0]  eb;
    for (int i = 8'h40; i < 8'h48; i++) mem[i] = $urandom;
    clear_sched();
    s_stall[17] = 1'b1;
    run(8'h40, 8'd2, 26);
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (outq[j].size() != 8) begin
        errors++; $display("FAIL sb_count col=%0d got %0d exp 8", j, outq[j].size());
      end else begin
        for (int t = 0; t < 2; t++) begin
          w = mem[8'h40 + t * 4 + j];
          for (int b = 0; b < 4; b++) begin
            eb = w[31 - 8 * b -: 8];
            checks++;
            if (outq[j][t * 4 + b] !== eb) begin
              errors++; $display("FAIL sb_byte col=%0d tile=%0d byte=%0d got %h exp %h", j, t, b, outq[j][t * 4 + b], eb);
            end
          end
        end
      end
    end
  endtask

  initial begin
    MemRdata = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    clear_sched();
    test_reset();
    test_basic();
    test_multi();
    test_stall();
    test_edges();
    test_reset_mid();
    test_scoreboard();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
